// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : counter_checker
//  Purpose  : Self-check monitor for a loadable WIDTH-bit up/down counter.
//             Snoops the counter's load/up_down/din controls and its count
//             output, runs a cycle-accurate reference model, flags and counts
//             mismatches, and captures the first failure for debug.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        width of din/count and of the reference model
//    ERR_W        width of the saturating mismatch counter
//    CYC_W        width of the check-cycle timestamp (and coverage counters)
//    STOP_ON_ERR  1 = stop checking (HALT) after the first mismatch until clr
//  Ports
//    clk          system clock, rising edge
//    rst_n        asynchronous active-low reset
//    chk_en       level request to check
//    clr          synchronous clear of error status, FSM back to IDLE
//    load         snooped counter load control
//    up_down      snooped direction (1 = up, 0 = down)
//    din          snooped load data
//    count        counter output under check
//    chk_active   high while the FSM is in CHECK
//    err_pulse    one-cycle pulse per recorded mismatch
//    err_sticky   set on first mismatch, held until clr/reset
//    err_cnt      saturating mismatch count
//    first_exp    model value at first mismatch
//    first_act    count value at first mismatch
//    first_cyc    check-cycle index of first mismatch
//  Optional build macro: COUNTER_CHECKER_COVER_EN
//    Adds cov_load, cov_wrap_up, cov_wrap_dn (CYC_W, saturating) counting,
//    during CHECK, load cycles, model up-wraps and model down-wraps.
// ============================================================================
module counter_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] count,
    output logic             chk_active,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic [CYC_W-1:0] first_cyc
`ifdef COUNTER_CHECKER_COVER_EN
    ,
    output logic [CYC_W-1:0] cov_load,
    output logic [CYC_W-1:0] cov_wrap_up,
    output logic [CYC_W-1:0] cov_wrap_dn
`endif
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] c_model_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_model_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_model_zero = '0;
    localparam logic [ERR_W-1:0] c_err_one    = ERR_W'(1);
    localparam logic [CYC_W-1:0] c_cyc_one    = CYC_W'(1);
    localparam bit               c_stop       = (STOP_ON_ERR != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_model;
    logic [CYC_W-1:0] r_cyc;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_cnt;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_act;
    logic [CYC_W-1:0] r_first_cyc;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             w_in_check;
    logic             w_mismatch;
    logic             w_record;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_model_nxt;
    logic             w_err_sat;
    logic             w_cyc_sat;

    assign w_in_check = (r_state == S_CHECK);

    // Both operands are the pre-edge values: the model holds what the
    // counter should be showing right now.
    assign w_mismatch = w_in_check && (count != r_model);

    // A simultaneous clr suppresses recording of the mismatch entirely.
    assign w_record   = w_mismatch && !clr;

    // On a mismatch the model adopts the observed count so a single
    // glitch is reported once rather than on every following cycle.
    assign w_base      = w_mismatch ? count : r_model;
    assign w_model_nxt = load    ? din :
                         up_down ? (w_base + c_model_one) :
                                   (w_base - c_model_one);

    assign w_err_sat = &r_err_cnt;
    assign w_cyc_sat = &r_cyc;

    // ------------------------------------------------------------------------
    // Reference model: tracks the counter in every state so that checking
    // can start at any time without a dedicated sync step.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model <= '0;
        end else begin
            r_model <= w_model_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and error status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
            r_first_cyc  <= '0;
        end else begin
            r_err_pulse <= w_record;

            if (clr) begin
                r_state      <= S_IDLE;
                r_cyc        <= '0;
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
                r_first_exp  <= '0;
                r_first_act  <= '0;
                r_first_cyc  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (chk_en) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        // Dropping the request takes precedence over halting.
                        if (!chk_en) begin
                            r_state <= S_IDLE;
                        end else if (w_mismatch && c_stop) begin
                            r_state <= S_HALT;
                        end
                    end
                    S_HALT: begin
                        r_state <= S_HALT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase

                // Timestamp advances only while comparing; held otherwise.
                if (w_in_check && !w_cyc_sat) begin
                    r_cyc <= r_cyc + c_cyc_one;
                end

                if (w_record) begin
                    r_err_sticky <= 1'b1;
                    if (!w_err_sat) begin
                        r_err_cnt <= r_err_cnt + c_err_one;
                    end
                    // Capture only the first failure since the last clear.
                    if (!r_err_sticky) begin
                        r_first_exp <= r_model;
                        r_first_act <= count;
                        r_first_cyc <= r_cyc;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional coverage counters (model-based, CHECK state only)
    // ------------------------------------------------------------------------
`ifdef COUNTER_CHECKER_COVER_EN
    logic [CYC_W-1:0] r_cov_load;
    logic [CYC_W-1:0] r_cov_wrap_up;
    logic [CYC_W-1:0] r_cov_wrap_dn;
    logic             w_hit_load;
    logic             w_hit_wrap_up;
    logic             w_hit_wrap_dn;

    assign w_hit_load    = w_in_check && load;
    assign w_hit_wrap_up = w_in_check && !load &&  up_down && (r_model == c_model_max);
    assign w_hit_wrap_dn = w_in_check && !load && !up_down && (r_model == c_model_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cov_load    <= '0;
            r_cov_wrap_up <= '0;
            r_cov_wrap_dn <= '0;
        end else if (clr) begin
            r_cov_load    <= '0;
            r_cov_wrap_up <= '0;
            r_cov_wrap_dn <= '0;
        end else begin
            if (w_hit_load && !(&r_cov_load)) begin
                r_cov_load <= r_cov_load + c_cyc_one;
            end
            if (w_hit_wrap_up && !(&r_cov_wrap_up)) begin
                r_cov_wrap_up <= r_cov_wrap_up + c_cyc_one;
            end
            if (w_hit_wrap_dn && !(&r_cov_wrap_dn)) begin
                r_cov_wrap_dn <= r_cov_wrap_dn + c_cyc_one;
            end
        end
    end

    assign cov_load    = r_cov_load;
    assign cov_wrap_up = r_cov_wrap_up;
    assign cov_wrap_dn = r_cov_wrap_dn;
`else
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign chk_active = w_in_check;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;
    assign first_exp  = r_first_exp;
    assign first_act  = r_first_act;
    assign first_cyc  = r_first_cyc;

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_checker
//  Purpose  : Directed self-checking bench for counter_checker. Two
//             instances share the snooped inputs: dut (STOP_ON_ERR=0) and
//             dut_s (STOP_ON_ERR=1). The bench plays the role of the counter,
//             corrupting its value on chosen cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_checker;

    localparam int W  = 4;
    localparam int EW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          chk_en;
    logic          clr;
    logic          load;
    logic          up_down;
    logic [W-1:0]  din;
    logic [W-1:0]  count;

    logic          chk_active,   chk_active_s;
    logic          err_pulse,    err_pulse_s;
    logic          err_sticky,   err_sticky_s;
    logic [EW-1:0] err_cnt,      err_cnt_s;
    logic [W-1:0]  first_exp,    first_exp_s;
    logic [W-1:0]  first_act,    first_act_s;
    logic [CW-1:0] first_cyc,    first_cyc_s;
`ifdef COUNTER_CHECKER_COVER_EN
    logic [CW-1:0] cov_load,    cov_load_s;
    logic [CW-1:0] cov_wrap_up, cov_wrap_up_s;
    logic [CW-1:0] cov_wrap_dn, cov_wrap_dn_s;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(W), .ERR_W(EW), .CYC_W(CW), .STOP_ON_ERR(0)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .load(load),
        .up_down(up_down), .din(din), .count(count),
        .chk_active(chk_active), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .first_exp(first_exp), .first_act(first_act),
        .first_cyc(first_cyc)
`ifdef COUNTER_CHECKER_COVER_EN
        , .cov_load(cov_load), .cov_wrap_up(cov_wrap_up), .cov_wrap_dn(cov_wrap_dn)
`endif
    );

    counter_checker #(.WIDTH(W), .ERR_W(EW), .CYC_W(CW), .STOP_ON_ERR(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .load(load),
        .up_down(up_down), .din(din), .count(count),
        .chk_active(chk_active_s), .err_pulse(err_pulse_s), .err_sticky(err_sticky_s),
        .err_cnt(err_cnt_s), .first_exp(first_exp_s), .first_act(first_act_s),
        .first_cyc(first_cyc_s)
`ifdef COUNTER_CHECKER_COVER_EN
        , .cov_load(cov_load_s), .cov_wrap_up(cov_wrap_up_s), .cov_wrap_dn(cov_wrap_dn_s)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock of the (bench-modelled) counter; inputs are sampled by the
    // DUT at the edge, the new count appears 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (load)         count = din;
        else if (up_down) count = count + 4'd1;
        else              count = count - 4'd1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0; load = 1'b0;
        up_down = 1'b1; din = '0; count = '0;

        // Reset state
        #12;
        check_eq("rst_chk_active", 32'(chk_active), 32'd0);
        check_eq("rst_err_cnt",    32'(err_cnt),    32'd0);
        check_eq("rst_err_sticky", 32'(err_sticky), 32'd0);
        check_eq("rst_first_cyc",  32'(first_cyc),  32'd0);
        rst_n = 1'b1;

        // Load 1011 then count up through the wrap
        chk_en = 1'b1;
        tick();
        load = 1'b1; din = 4'b1011;
        tick();
        load = 1'b0;
        tick_n(10);
        check_eq("up_chk_active", 32'(chk_active), 32'd1);
        check_eq("up_err_cnt",    32'(err_cnt),    32'd0);
        check_eq("up_err_sticky", 32'(err_sticky), 32'd0);
        check_eq("up_s_err_cnt",  32'(err_cnt_s),  32'd0);
`ifdef COUNTER_CHECKER_COVER_EN
        check_eq("up_cov_load",    32'(cov_load),    32'd1);
        check_eq("up_cov_wrap_up", 32'(cov_wrap_up), 32'd1);
`endif

        // Load 0001 then count down through the wrap
        load = 1'b1; din = 4'b0001;
        tick();
        load = 1'b0; up_down = 1'b0;
        tick_n(5);
        check_eq("dn_err_cnt",    32'(err_cnt),    32'd0);
        check_eq("dn_err_sticky", 32'(err_sticky), 32'd0);
`ifdef COUNTER_CHECKER_COVER_EN
        check_eq("dn_cov_load",    32'(cov_load),    32'd2);
        check_eq("dn_cov_wrap_dn", 32'(cov_wrap_dn), 32'd1);
`endif

        // Single glitch: model expects 0110, counter shows 0111
        load = 1'b1; din = 4'b0101; up_down = 1'b1;
        tick();
        load = 1'b0;
        tick();
        count = 4'b0111;
        tick();
        check_eq("inj_err_pulse",  32'(err_pulse),  32'd1);
        check_eq("inj_err_cnt",    32'(err_cnt),    32'd1);
        check_eq("inj_err_sticky", 32'(err_sticky), 32'd1);
        check_eq("inj_first_exp",  32'(first_exp),  32'd6);
        check_eq("inj_first_act",  32'(first_act),  32'd7);
        check_eq("inj_first_cyc",  32'(first_cyc),  32'd19);
        check_eq("inj_s_active",   32'(chk_active_s), 32'd0);
        check_eq("inj_s_err_cnt",  32'(err_cnt_s),  32'd1);
        tick();
        check_eq("resync_err_pulse", 32'(err_pulse), 32'd0);
        check_eq("resync_err_cnt",   32'(err_cnt),   32'd1);

        // Second glitch: halted instance ignores it
        count = count + 4'd3;
        tick();
        check_eq("inj2_err_cnt",   32'(err_cnt),   32'd2);
        check_eq("inj2_first_act", 32'(first_act), 32'd7);
        check_eq("inj2_s_err_cnt", 32'(err_cnt_s), 32'd1);
        check_eq("inj2_s_pulse",   32'(err_pulse_s), 32'd0);

        // clr (with a load to realign both models)
        clr = 1'b1; load = 1'b1; din = 4'd0;
        tick();
        clr = 1'b0; load = 1'b0;
        check_eq("clr_s_active",    32'(chk_active_s), 32'd0);
        check_eq("clr_s_err_cnt",   32'(err_cnt_s),    32'd0);
        check_eq("clr_s_sticky",    32'(err_sticky_s), 32'd0);
        check_eq("clr_s_first_exp", 32'(first_exp_s),  32'd0);
        check_eq("clr_s_first_act", 32'(first_act_s),  32'd0);
        check_eq("clr_s_first_cyc", 32'(first_cyc_s),  32'd0);
        check_eq("clr_err_cnt",     32'(err_cnt),      32'd0);
        check_eq("clr_chk_active",  32'(chk_active),   32'd0);
        tick();
        check_eq("reen_chk_active",   32'(chk_active),   32'd1);
        check_eq("reen_s_chk_active", 32'(chk_active_s), 32'd1);

        // 300 consecutive mismatches: counter saturates, capture holds
        for (int i = 0; i < 300; i++) begin
            count = count + 4'd4;
            tick();
        end
        check_eq("sat_err_pulse", 32'(err_pulse), 32'd1);
        check_eq("sat_err_cnt",   32'(err_cnt),   32'd255);
        check_eq("sat_first_exp", 32'(first_exp), 32'd1);
        check_eq("sat_first_act", 32'(first_act), 32'd5);
        check_eq("sat_first_cyc", 32'(first_cyc), 32'd0);
        check_eq("sat_s_err_cnt", 32'(err_cnt_s), 32'd1);
        check_eq("sat_s_first_act", 32'(first_act_s), 32'd5);
        tick();
        check_eq("sat_quiet_pulse", 32'(err_pulse), 32'd0);
        check_eq("sat_hold_cnt",    32'(err_cnt),   32'd255);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0; count = '0;
        #1;
        check_eq("arst_err_cnt",    32'(err_cnt),    32'd0);
        check_eq("arst_err_sticky", 32'(err_sticky), 32'd0);
        check_eq("arst_chk_active", 32'(chk_active), 32'd0);
        check_eq("arst_first_act",  32'(first_act),  32'd0);
        check_eq("arst_err_pulse",  32'(err_pulse),  32'd0);
        check_eq("arst_s_err_cnt",  32'(err_cnt_s),  32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        tick_n(3);
        check_eq("post_rst_active", 32'(chk_active), 32'd1);
        check_eq("post_rst_err",    32'(err_cnt),    32'd0);
        check_eq("post_rst_sticky", 32'(err_sticky), 32'd0);
        check_eq("post_rst_s_err",  32'(err_cnt_s),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Hardware self-check monitor for the loadable up/down counter. It sits beside the counter, snooping the same `load`, `up_down` and `din` controls plus the counter's `count` output.
- It runs a cycle-accurate reference model, flags mismatches, counts them, and captures the first failure for debug.
- It is the consumer/checking end of the counter's interface; the counter is the producer.

Parameters:
- WIDTH, 4, width of din/count and of the internal model.
- ERR_W, 8, width of the saturating error counter.
- CYC_W, 16, width of the check-cycle timestamp counter.
- STOP_ON_ERR, 0, 1 = halt checking after the first mismatch until cleared.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset, shared with the counter.
- chk_en  input  1  level; request checking.
- clr  input  1  synchronous clear of error status; returns FSM to IDLE.
- load  input  1  snooped counter load control.
- up_down  input  1  snooped direction (1 = up, 0 = down).
- din  input  WIDTH  snooped load data.
- count  input  WIDTH  counter output under check.
- chk_active  output  1  high while FSM is in CHECK.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- err_sticky  output  1  set on first mismatch, held until clr or reset.
- err_cnt  output  ERR_W  mismatch count, saturates at all-ones.
- first_exp  output  WIDTH  model value at first mismatch.
- first_act  output  WIDTH  count value at first mismatch.
- first_cyc  output  CYC_W  check-cycle index of first mismatch.

Behaviour:
- Reset (rst_n low, async):
  - model = 0, state = IDLE, cyc = 0.
  - All outputs 0.
- Counter contract being checked:
  - count resets to 0.
  - Each rising edge: load=1 gives count <= din; else up_down=1 gives count+1; else count-1.
  - Arithmetic is modulo 2^WIDTH: 15+1 = 0, 0-1 = 15.
- Model update, every rising edge in every state (rst_n high):
  - base = model, or count if a mismatch is detected this edge (resync).
  - model <= load ? din : (up_down ? base+1 : base-1), WIDTH-bit wrap.
- Comparison: at each rising edge while state = CHECK, mismatch = (count != model). Both values are pre-edge.
- FSM:
  - IDLE: chk_en=1 -> CHECK.
  - CHECK: chk_en=0 -> IDLE. Mismatch with STOP_ON_ERR=1 -> HALT. Otherwise stay.
  - HALT: no comparisons, chk_active=0. Leave only via clr -> IDLE.
  - clr has priority over every other transition. clr=1 in any state -> IDLE next edge, and clears err_cnt, err_sticky, first_exp, first_act, first_cyc and cyc.
- Latency: a mismatch seen at edge N gives err_pulse high, err_cnt increment and sticky set, all visible after edge N (one-cycle registered).
- cyc: increments each edge in CHECK, saturates at all-ones. It is reported via first_cyc.
- First-error capture:
  - Occurs only when err_sticky was 0 at that edge.
  - Records model, count and cyc.
  - Later mismatches do not overwrite the capture.
- err_cnt saturation: at all-ones, further mismatches still pulse err_pulse but do not wrap.
- Simultaneous clr and mismatch: clr wins; no error is recorded.
- chk_en dropped mid-run: errors and capture are retained; cyc is held; the model keeps tracking.
- rst_n asserted mid-operation: everything returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: COUNTER_CHECKER_COVER_EN.
- When defined:
  - Adds outputs cov_load, cov_wrap_up and cov_wrap_dn, each CYC_W wide and saturating.
  - They count, during CHECK only: load cycles; up-steps from all-ones to 0; down-steps from 0 to all-ones. All based on model.
  - Reset and clr both set them to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then chk_en=1; load din=1011 for one cycle; up_down=1 for 10 cycles, correct counter -> count 1011..1111,0000..0101; err_sticky=0, err_cnt=0; with COVER_EN, cov_wrap_up=1 and cov_load=1.
- Down-count wrap: after load 0001, up_down=0 for 5 cycles -> count 0001,0000,1111,1110,1101 accepted, no errors.
- Force count to 0111 for one cycle when model expects 0110 -> err_pulse one cycle, err_cnt=1, first_exp=0110, first_act=0111; model resyncs, giving no further errors.
- STOP_ON_ERR=1, inject mismatch -> chk_active drops, FSM in HALT. A second injected mismatch leaves err_cnt=1. clr -> all status 0, IDLE.
- Inject 300 mismatches with ERR_W=8 -> err_cnt holds at 255; first_* keep the first failure's values.
- Assert rst_n=0 mid-CHECK, between edges -> all outputs 0 immediately; after release with chk_en=1, checking resumes with model=0.
